// File: rtl/dac_send.sv
// -----------------------------------------------------------------------------
// dac_send
// Plays a stream of mono samples to an I2S audio codec DAC. Samples are queued
// in a small FIFO. Each left-channel frame (daclrck falling edge) pops one word
// into a hold register. The word is then serialised MSB-first on both the left
// and right channels, with a one-bit I2S delay after each frame clock edge.
// The codec clocks are sampled in the clk domain through 2-flop synchronizers.
//
// Ports:
//   clk             - system clock, at least 4x the bit clock
//   reset           - asynchronous active-high reset
//   sample_data     - N-bit two's complement sample to queue
//   sample_valid    - sample_data is valid this cycle
//   sample_ready    - FIFO has room (combinational from fifo_level)
//   bclk            - codec bit clock (asynchronous)
//   daclrck         - codec frame clock, low = left, high = right (asynchronous)
//   dacdat          - serial data to codec, registered
//   fifo_level      - number of words currently stored
//   underflow       - one-cycle pulse when a left frame starts with empty FIFO
//   underflow_count - saturating count of underflow events
// -----------------------------------------------------------------------------
module dac_send #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           sample_data,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic                   bclk,
    input  logic                   daclrck,
    output logic                   dacdat,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underflow,
    output logic [7:0]             underflow_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(N + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [BW-1:0] BITS_WORD  = BW'(N);
    localparam logic [BW-1:0] BITS_ONE   = BW'(1);

    // Synchronizer chains: meta -> sync, plus a history flop for edge detection
    logic bclk_meta_r, bclk_sync_r, bclk_hist_r;
    logic lrc_meta_r,  lrc_sync_r,  lrc_hist_r;

    // FIFO storage and pointers (pointers wrap naturally, DEPTH is a power of two)
    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;

    // Serialiser state
    logic          armed_r;
    logic [N-1:0]  hold_r;
    logic [N-1:0]  shifter_r;
    logic [BW-1:0] bits_left_r;

    logic bclk_fall_s;
    logic lrc_fall_s;
    logic lrc_rise_s;
    logic fifo_empty_s;
    logic push_s;
    logic pop_s;
    logic starve_s;
    logic [N-1:0] next_word_s;

    assign bclk_fall_s  = bclk_hist_r & ~bclk_sync_r;
    assign lrc_fall_s   = lrc_hist_r  & ~lrc_sync_r;
    assign lrc_rise_s   = ~lrc_hist_r & lrc_sync_r;

    assign fifo_empty_s = (fifo_level == '0);
    assign sample_ready = (fifo_level < LEVEL_FULL);
    assign push_s       = sample_valid & sample_ready;
    // Every left-frame start consumes a word, even before arming: the first
    // falling edge is the one that arms the serialiser.
    assign pop_s        = lrc_fall_s & ~fifo_empty_s;
    assign starve_s     = lrc_fall_s & fifo_empty_s;
    assign next_word_s  = fifo_empty_s ? '0 : mem_r[rd_ptr_r];

    // Synchronize bclk and daclrck through identical chains so coincident pin
    // edges are seen in the same clk cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_meta_r <= 1'b0;
            bclk_sync_r <= 1'b0;
            bclk_hist_r <= 1'b0;
            lrc_meta_r  <= 1'b0;
            lrc_sync_r  <= 1'b0;
            lrc_hist_r  <= 1'b0;
        end else begin
            bclk_meta_r <= bclk;
            bclk_sync_r <= bclk_meta_r;
            bclk_hist_r <= bclk_sync_r;
            lrc_meta_r  <= daclrck;
            lrc_sync_r  <= lrc_meta_r;
            lrc_hist_r  <= lrc_sync_r;
        end
    end

    // FIFO write side, read pointer and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_level <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sample_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Underflow pulse and saturating event counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow       <= 1'b0;
            underflow_count <= 8'd0;
        end else begin
            underflow <= starve_s;
            if (starve_s && (underflow_count != 8'hFF)) begin
                underflow_count <= underflow_count + 8'd1;
            end
        end
    end

    // Serialiser: frame edges reload the shifter (and take priority over a
    // coincident bit-clock edge); later bclk falls shift out MSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_r     <= 1'b0;
            hold_r      <= '0;
            shifter_r   <= '0;
            bits_left_r <= '0;
            dacdat      <= 1'b0;
        end else begin
            if (lrc_fall_s) begin
                armed_r     <= 1'b1;
                hold_r      <= next_word_s;
                shifter_r   <= next_word_s;
                bits_left_r <= BITS_WORD;
                dacdat      <= 1'b0;
            end else if (lrc_rise_s && armed_r) begin
                // Right channel repeats the left sample
                shifter_r   <= hold_r;
                bits_left_r <= BITS_WORD;
                dacdat      <= 1'b0;
            end else if (bclk_fall_s && armed_r) begin
                if (bits_left_r != '0) begin
                    dacdat      <= shifter_r[N-1];
                    shifter_r   <= {shifter_r[N-2:0], 1'b0};
                    bits_left_r <= bits_left_r - BITS_ONE;
                end else begin
                    dacdat <= 1'b0;
                end
            end
        end
    end

endmodule
